// File: rtl/game_scan_gen.sv
// game_scan_gen: VGA raster timing plus scan of the 224x288 game plane at an integer upscale.
// Latency: every output is registered one cycle behind the (hc,vc) position counters.
// Backpressure: none; this is a free-running source and the consumer has to keep pace with the pixel clock.
//
// Ports:
//   vga_pix_clk, rst        - pixel clock; synchronous active-high reset
//   hsync, vsync, vga_de    - physical monitor timing
//   display_enabled, sx, sy - game window flag and game-plane coordinates
//   game_pix_stb            - first physical pixel of each game pixel
//   frame_stb               - one pulse per frame, at position (0,0)
module game_scan_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit SYNC_POL  = 1'b1,
  parameter int GAME_W    = 224,
  parameter int GAME_H    = 288,
  parameter int SCALE     = 2,
  parameter int H_OFF     = 176,
  parameter int V_OFF     = 12
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic                      display_enabled,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The counters carry one spare code so that every boundary constant,
  // including a full total, fits without truncation.
  localparam int HCW = $clog2(H_TOTAL + 1);
  localparam int VCW = $clog2(V_TOTAL + 1);
  localparam int SXW = $clog2(GAME_W);
  localparam int SYW = $clog2(GAME_H);
  localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HCW-1:0] HC_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] HC_VIS   = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] HC_OFF   = HCW'(H_OFF);
  localparam logic [HCW-1:0] HC_SPAN  = HCW'(GAME_W * SCALE);
  localparam logic [HCW-1:0] HS_START = HCW'(H_VISIBLE + H_FRONT);
  localparam logic [HCW-1:0] HS_LEN   = HCW'(H_SYNC);

  localparam logic [VCW-1:0] VC_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] VC_VIS   = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] VC_OFF   = VCW'(V_OFF);
  localparam logic [VCW-1:0] VC_SPAN  = VCW'(GAME_H * SCALE);
  localparam logic [VCW-1:0] VS_START = VCW'(V_VISIBLE + V_FRONT);
  localparam logic [VCW-1:0] VS_LEN   = VCW'(V_SYNC);

  localparam logic [SW-1:0]  SUB_LAST = SW'(SCALE - 1);

  // Elaboration-time sanity of the window placement.
  if (SCALE < 1) begin : g_bad_scale
    $error("game_scan_gen: SCALE must be at least 1");
  end
  if (H_OFF + GAME_W * SCALE > H_VISIBLE) begin : g_bad_h
    $error("game_scan_gen: game window exceeds horizontal visible area");
  end
  if (V_OFF + GAME_H * SCALE > V_VISIBLE) begin : g_bad_v
    $error("game_scan_gen: game window exceeds vertical visible area");
  end

  logic [HCW-1:0] hc, hc_n;
  logic [VCW-1:0] vc, vc_n;
  logic [SW-1:0]  hsub, hsub_n, vsub, vsub_n;
  logic [SXW-1:0] gx, gx_n;
  logic [SYW-1:0] gy, gy_n;
  logic           line_end;
  logic           in_h, in_v, in_h_n, in_v_n;

  // Range checks use one unsigned subtract: positions left of/above the
  // window wrap to a value far larger than the span.
  always_comb begin
    line_end = (hc == HC_LAST);
    hc_n     = line_end ? '0 : hc + 1'b1;
    vc_n     = vc;
    if (line_end) begin
      vc_n = (vc == VC_LAST) ? '0 : vc + 1'b1;
    end

    in_h   = (hc   - HC_OFF) < HC_SPAN;
    in_v   = (vc   - VC_OFF) < VC_SPAN;
    in_h_n = (hc_n - HC_OFF) < HC_SPAN;
    in_v_n = (vc_n - VC_OFF) < VC_SPAN;
  end

  // hsub/gx track (hc-H_OFF) mod/div SCALE incrementally, zero outside.
  always_comb begin
    hsub_n = '0;
    gx_n   = '0;
    if (in_h_n && in_h) begin
      if (hsub == SUB_LAST) begin
        gx_n = gx + 1'b1;
      end else begin
        hsub_n = hsub + 1'b1;
        gx_n   = gx;
      end
    end
  end

  // vsub/gy advance only at the end of a line.
  always_comb begin
    vsub_n = vsub;
    gy_n   = gy;
    if (line_end) begin
      vsub_n = '0;
      gy_n   = '0;
      if (in_v_n && in_v) begin
        if (vsub == SUB_LAST) begin
          gy_n = gy + 1'b1;
        end else begin
          vsub_n = vsub + 1'b1;
          gy_n   = gy;
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hc              <= '0;
      vc              <= '0;
      hsub            <= '0;
      vsub            <= '0;
      gx              <= '0;
      gy              <= '0;
      hsync           <= ~SYNC_POL;
      vsync           <= ~SYNC_POL;
      vga_de          <= 1'b0;
      display_enabled <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
    end else begin
      hc              <= hc_n;
      vc              <= vc_n;
      hsub            <= hsub_n;
      vsub            <= vsub_n;
      gx              <= gx_n;
      gy              <= gy_n;
      hsync           <= ((hc - HS_START) < HS_LEN) ? SYNC_POL : ~SYNC_POL;
      vsync           <= ((vc - VS_START) < VS_LEN) ? SYNC_POL : ~SYNC_POL;
      vga_de          <= (hc < HC_VIS) && (vc < VC_VIS);
      display_enabled <= in_h && in_v;
      sx              <= in_h ? gx : '0;
      sy              <= in_v ? gy : '0;
      game_pix_stb    <= in_h && in_v && (hsub == '0) && (vsub == '0);
      frame_stb       <= (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_game_scan_gen.sv
// Directed bench for game_scan_gen on a reduced raster (56x36 total) so that
// whole frames fit in a short run; a second SCALE=1, active-low-sync build runs alongside.
module tb_game_scan_gen;

  localparam int HT = 56;
  localparam int VT = 36;
  localparam int FR = HT * VT;   // 2016 cycles per frame

  logic       vga_pix_clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_hsync, a_vsync, a_vga_de, a_de, a_gps, a_fstb;
  logic [3:0] a_sx, a_sy;
  logic       b_hsync, b_vsync, b_vga_de, b_de, b_gps, b_fstb;
  logic [3:0] b_sx, b_sy;

  always #5 vga_pix_clk = ~vga_pix_clk;

  // A: SCALE=2, window hc 8..31, vc 4..23, game 12x10.
  game_scan_gen #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(30), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b1), .GAME_W(12), .GAME_H(10), .SCALE(2),
    .H_OFF(8), .V_OFF(4)
  ) u_a (
    .vga_pix_clk(vga_pix_clk), .rst(rst),
    .hsync(a_hsync), .vsync(a_vsync), .vga_de(a_vga_de),
    .display_enabled(a_de), .sx(a_sx), .sy(a_sy),
    .game_pix_stb(a_gps), .frame_stb(a_fstb)
  );

  // B: SCALE=1, window at origin 16x12, active-low sync.
  game_scan_gen #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(30), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b0), .GAME_W(16), .GAME_H(12), .SCALE(1),
    .H_OFF(0), .V_OFF(0)
  ) u_b (
    .vga_pix_clk(vga_pix_clk), .rst(rst),
    .hsync(b_hsync), .vsync(b_vsync), .vga_de(b_vga_de),
    .display_enabled(b_de), .sx(b_sx), .sy(b_sy),
    .game_pix_stb(b_gps), .frame_stb(b_fstb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;   // raster position currently shown on the outputs

  int h, v;
  int last_f, n_f, intv0, intv1, gps_cnt, gps_f0, gps_f1, back2back, b_err;
  logic prev_gps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step output cycles until the outputs describe position (hh,vv).
  task automatic adv_to(input int hh, input int vv);
    int target;
    int guard;
    target = vv * HT + hh;
    guard  = 0;
    while (pos != target && guard < FR + 4) begin
      @(negedge vga_pix_clk);
      pos = (pos + 1) % FR;
      guard++;
    end
    if (pos != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL adv_to: reached %0d expected %0d", pos, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(posedge vga_pix_clk);
    @(negedge vga_pix_clk);
    chk("rst_hsync", a_hsync, 0);
    chk("rst_vsync", a_vsync, 0);
    chk("rst_vga_de", a_vga_de, 0);
    chk("rst_de", a_de, 0);
    chk("rst_sx", a_sx, 0);
    chk("rst_sy", a_sy, 0);
    chk("rst_gps", a_gps, 0);
    chk("rst_fstb", a_fstb, 0);
    chk("rst_b_hsync", b_hsync, 1);
    chk("rst_b_vsync", b_vsync, 1);

    // First output cycle after release shows (0,0).
    rst = 1'b0;
    @(negedge vga_pix_clk);
    pos = 0;
    chk("rel_fstb", a_fstb, 1);
    chk("rel_sx", a_sx, 0);
    chk("rel_sy", a_sy, 0);
    chk("rel_vga_de", a_vga_de, 1);
    chk("rel_de", a_de, 0);
    chk("rel_b_fstb", b_fstb, 1);
    @(negedge vga_pix_clk);
    pos = 1;
    chk("rel_fstb_next", a_fstb, 0);

    // Window edges.
    adv_to(7, 4);   chk("w7_4_de", a_de, 0);
    adv_to(8, 4);   chk("w8_4_de", a_de, 1);  chk("w8_4_sx", a_sx, 0);
                    chk("w8_4_sy", a_sy, 0);  chk("w8_4_gps", a_gps, 1);
    adv_to(9, 4);   chk("w9_4_gps", a_gps, 0); chk("w9_4_sx", a_sx, 0);
    adv_to(10, 4);  chk("w10_4_gps", a_gps, 1); chk("w10_4_sx", a_sx, 1);
    adv_to(8, 5);   chk("w8_5_gps", a_gps, 0); chk("w8_5_sy", a_sy, 0);
                    chk("w8_5_de", a_de, 1);
    adv_to(31, 23); chk("w31_23_sx", a_sx, 11); chk("w31_23_sy", a_sy, 9);
                    chk("w31_23_de", a_de, 1);
    adv_to(32, 23); chk("w32_23_de", a_de, 0); chk("w32_23_sx", a_sx, 0);
    adv_to(8, 24);  chk("w8_24_de", a_de, 0);  chk("w8_24_sy", a_sy, 0);

    // Physical timing: hsync hc 44..49, vsync vc 31..32, visible 40x30.
    adv_to(39, 24); chk("vde_39", a_vga_de, 1);
    adv_to(40, 24); chk("vde_40", a_vga_de, 0);
    adv_to(43, 24); chk("hs_43", a_hsync, 0); chk("b_hs_43", b_hsync, 1);
    adv_to(44, 24); chk("hs_44", a_hsync, 1); chk("b_hs_44", b_hsync, 0);
    adv_to(49, 24); chk("hs_49", a_hsync, 1);
    adv_to(50, 24); chk("hs_50", a_hsync, 0);
    adv_to(0, 30);  chk("vs_30", a_vsync, 0); chk("vde_row30", a_vga_de, 0);
    adv_to(0, 31);  chk("vs_31", a_vsync, 1);
    adv_to(55, 32); chk("vs_32", a_vsync, 1);
    adv_to(0, 33);  chk("vs_33", a_vsync, 0);

    // Two full frames: strobe spacing, pulse counts, SCALE=1 invariants.
    adv_to(55, 35);
    last_f = -1; n_f = 0; intv0 = 0; intv1 = 0;
    gps_cnt = 0; gps_f0 = 0; gps_f1 = 0; back2back = 0; b_err = 0;
    prev_gps = 1'b0;
    for (int i = 0; i <= 2 * FR; i++) begin
      @(negedge vga_pix_clk);
      pos = (pos + 1) % FR;
      h = pos % HT;
      v = pos / HT;
      if (a_fstb === 1'b1) begin
        if (n_f == 1) begin intv0 = i - last_f; gps_f0 = gps_cnt; end
        if (n_f == 2) begin intv1 = i - last_f; gps_f1 = gps_cnt; end
        last_f = i;
        n_f++;
        gps_cnt = 0;
      end
      if (a_gps === 1'b1) gps_cnt++;
      if (prev_gps === 1'b1 && a_gps === 1'b1) back2back++;
      prev_gps = a_gps;
      if (b_gps !== b_de) b_err++;
      if (b_de !== ((h < 16) && (v < 12))) b_err++;
      if (b_de === 1'b1 && (b_sx !== 4'(h) || b_sy !== 4'(v))) b_err++;
    end
    chk("frame_pulses", n_f, 3);
    chk("frame_period0", intv0, FR);
    chk("frame_period1", intv1, FR);
    chk("gps_per_frame0", gps_f0, 120);
    chk("gps_per_frame1", gps_f1, 120);
    chk("gps_back_to_back", back2back, 0);
    chk("scale1_errors", b_err, 0);

    // Reset mid-frame on the edge that would have produced a game pixel strobe at (20,14).
    adv_to(19, 14);
    chk("pre_rst_de", a_de, 1);
    rst = 1'b1;
    @(negedge vga_pix_clk);
    chk("mid_rst_gps", a_gps, 0);
    chk("mid_rst_de", a_de, 0);
    chk("mid_rst_vga_de", a_vga_de, 0);
    chk("mid_rst_sx", a_sx, 0);
    chk("mid_rst_sy", a_sy, 0);
    chk("mid_rst_fstb", a_fstb, 0);
    rst = 1'b0;
    @(negedge vga_pix_clk);
    pos = 0;
    chk("restart_fstb", a_fstb, 1);
    chk("restart_sx", a_sx, 0);
    chk("restart_sy", a_sy, 0);
    @(negedge vga_pix_clk);
    pos = 1;
    chk("restart_fstb_next", a_fstb, 0);
    adv_to(8, 4);
    chk("restart_w8_4_gps", a_gps, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_scan_gen.md
# game_scan_gen

Raster timing generator and game-space scan source for the Pacman display path. It runs a VGA pixel counter on `vga_pix_clk` and produces `hsync`/`vsync` for the monitor. It also maps each physical pixel into the 224x288 game plane at an integer upscale, emitting `sx`, `sy`, `game_pix_stb`, `frame_stb` and `display_enabled`, which drive the game renderer. It is the producing end of the scan interface that `pacman_game` consumes.

## Interface
Parameters:
- `H_VISIBLE`, 800: active pixels per line
- `H_FRONT`, 40: horizontal front porch
- `H_SYNC`, 128: horizontal sync width
- `H_BACK`, 88: horizontal back porch
- `V_VISIBLE`, 600: active lines
- `V_FRONT`, 1: vertical front porch
- `V_SYNC`, 4: vertical sync width
- `V_BACK`, 23: vertical back porch
- `SYNC_POL`, 1: asserted sync level (1 = active-high)
- `GAME_W`, 224: game plane width in game pixels
- `GAME_H`, 288: game plane height in game pixels
- `SCALE`, 2: physical pixels per game pixel, in each axis; must be ≥1
- `H_OFF`, 176: first physical column of the game window
- `V_OFF`, 12: first physical line of the game window

Ports:
- `vga_pix_clk`, in, 1: pixel clock, the only clock
- `rst`, in, 1: synchronous, active-high reset
- `hsync`, out, 1: horizontal sync
- `vsync`, out, 1: vertical sync
- `vga_de`, out, 1: physical visible area
- `display_enabled`, out, 1: pixel lies inside the game window
- `sx`, out, $clog2(GAME_W): game column
- `sy`, out, $clog2(GAME_H): game row
- `game_pix_stb`, out, 1: first physical pixel of a game pixel
- `frame_stb`, out, 1: one cycle per frame

## Operation
- **Totals.** H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1056). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (628).
- **Elaboration checks.** H_OFF+GAME_W*SCALE ≤ H_VISIBLE and V_OFF+GAME_H*SCALE ≤ V_VISIBLE. Violating either is an elaboration error.
- **Position counters.** `hc` counts 0..H_TOTAL-1 and wraps to 0. `vc` increments when `hc` wraps, and `vc` wraps to 0 at V_TOTAL-1.
- **Sub-pixel counters.** `hsub` and `vsub` count 0..SCALE-1 inside the window. `sx`/`sy` are derived from these counters; no divider is used.
- **Game window.**
  - in_h = H_OFF ≤ hc < H_OFF+GAME_W*SCALE.
  - in_v = V_OFF ≤ vc < V_OFF+GAME_H*SCALE.
  - `display_enabled` = in_h & in_v.
- **Game coordinates.**
  - `sx` = (hc-H_OFF)/SCALE when in_h, else 0.
  - `sy` = (vc-V_OFF)/SCALE when in_v, else 0.
  - `sx` never exceeds GAME_W-1 and `sy` never exceeds GAME_H-1.
- **Strobes.**
  - `game_pix_stb` = `display_enabled` & ((hc-H_OFF) mod SCALE == 0) & ((vc-V_OFF) mod SCALE == 0). This gives exactly GAME_W*GAME_H pulses per frame.
  - `frame_stb` = (hc==0 & vc==0). At that point `sx`=`sy`=0.
- **Physical outputs.**
  - `vga_de` = hc < H_VISIBLE & vc < V_VISIBLE.
  - `hsync` = SYNC_POL while H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC, else !SYNC_POL.
  - `vsync` follows the same rule on `vc` with the V_* parameters.
- **SCALE=1.** `game_pix_stb` equals `display_enabled`.

## Timing
- **Registered outputs.** All outputs are registered and mutually aligned. Every output in a given cycle describes the same (hc,vc).
- **Latency.** Outputs describe the counter value sampled at the previous edge, i.e. one cycle of latency from counter to outputs.
- **Reset.**
  - On an edge with `rst`=1: hc, vc, hsub and vsub go to 0.
  - Outputs take their reset values: `hsync`=`vsync`=!SYNC_POL, and `vga_de`, `display_enabled`, `sx`, `sy`, `game_pix_stb`, `frame_stb` all 0.
- **First edge after reset.** The first edge with `rst`=0 presents position (0,0), so `frame_stb`=1 for exactly that cycle.
- **Reset mid-frame.** Aborts the frame immediately. No partial strobe is emitted on the reset edge. The restart is identical to power-up.
- **Strobe widths.** `frame_stb` is one cycle every H_TOTAL*V_TOTAL cycles (663168 at defaults). `game_pix_stb` is never high for two consecutive cycles when SCALE ≥ 2.
- **Window edges.** `sx` increments on the cycle after `hsub` wraps. At the last window column `sx`=GAME_W-1, and on the next column `sx`=0 with `display_enabled`=0. `sy` behaves the same way at the row boundary.

## Test plan
- **Reset release.** Hold `rst` 3 cycles, then release. Required: all outputs at reset values while `rst`=1; `frame_stb`=1, `sx`=0, `sy`=0 on the first output cycle after release; `frame_stb`=0 on the next cycle.
- **Frame period.** Run 2 full frames and count cycles. Required: `frame_stb` pulses exactly 663168 cycles apart; `game_pix_stb` pulses exactly 64512 times per frame.
- **Window boundaries at defaults.**
  - (hc,vc)=(175,12): `display_enabled`=0.
  - (176,12): `display_enabled`=1, `sx`=0, `sy`=0, `game_pix_stb`=1.
  - (177,12): `game_pix_stb`=0, `sx`=0.
  - (623,587): `sx`=223, `sy`=287.
  - (624,587): `display_enabled`=0, `sx`=0.
- **Sync at defaults.**
  - `hsync`=1 for hc 840..967 inclusive, else 0.
  - `vsync`=1 for vc 601..604, else 0.
  - `vga_de`=0 from hc=800.
- **Reset mid-frame.** Assert `rst` at (500,300) for 1 cycle. Required: outputs go to reset values on that edge; the next cycle shows `frame_stb`=1 at (0,0); there is no `game_pix_stb` on the reset cycle.
- **SCALE=1 build** (GAME 224x288, H_OFF=0, V_OFF=0). Required: `game_pix_stb` equals `display_enabled` every cycle; `sx` equals hc inside the window.
